// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg                                                                   |
// | Shared encodings for the configurable UART receiver.                       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned C_MIN_DIV = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5,
        ST_DONE   = 3'd6
    } uart_state_t;

    // Mode 2'b11 is deliberately treated as "no parity".
    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_baud_cnt                                                              |
// | Loadable down-counter; expire is high while the count equals one.          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_baud_cnt #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             expire
);

    localparam logic [DIV_W-1:0] C_ONE = DIV_W'(1);

    logic [DIV_W-1:0] r_count;

    // Parks at zero once run out so an unreloaded counter never re-expires.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - C_ONE;
        end
    end

    assign expire = (r_count == C_ONE);

endmodule
`default_nettype wire

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_cfg                                                                |
// | Runtime-configurable UART receiver with valid/ready output register.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned       DATA_W        = 8,
    parameter int unsigned       DIV_W         = 16,
    parameter logic [DIV_W-1:0]  DEFAULT_DIV   = DIV_W'(10416),
    parameter logic [1:0]        DEFAULT_PAR   = 2'b00,
    parameter logic              DEFAULT_STOP2 = 1'b0,
    parameter int unsigned       MIN_DIV       = C_MIN_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    input  logic              cfg_load,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [1:0]        cfg_par,
    input  logic              cfg_stop2,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_par_err,
    output logic              rx_frame_err,
    output logic              rx_break,
    output logic              rx_overrun,
    output logic              busy
);

    localparam int unsigned      C_BC_W    = $clog2(DATA_W + 1);
    localparam logic [DIV_W-1:0] C_MIN     = DIV_W'(MIN_DIV);
    localparam logic [C_BC_W-1:0] C_LAST_BIT = C_BC_W'(DATA_W - 1);

    logic              r_sync1, r_sync2, r_prev;
    logic              w_line, w_fall;
    uart_state_t       r_state, w_state_next;
    logic [DIV_W-1:0]  r_div, r_pend_div, w_cfg_div;
    logic [1:0]        r_par, r_pend_par;
    logic              r_stop2, r_pend_stop2, r_pend_vld;
    logic              w_cnt_load, w_expire, w_enter_idle, w_par_calc;
    logic [DIV_W-1:0]  w_cnt_val;
    logic [DATA_W-1:0] r_shift;
    logic [C_BC_W-1:0] r_bit_cnt;
    logic              r_par_acc, r_frame_acc, r_break_acc, r_zero;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_valid, r_rx_par, r_rx_frame, r_rx_break, r_rx_ovr;
    logic              w_hs;

    // Two-flop synchroniser; preset high so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_line = r_sync2;
    assign w_fall = r_prev & ~w_line;

    uart_baud_cnt #(.DIV_W(DIV_W)) u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (w_cnt_val),
        .expire   (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_val    = r_div;
        case (r_state)
            ST_IDLE: begin
                if (w_fall) begin
                    w_state_next = ST_START;
                    w_cnt_load   = 1'b1;
                    w_cnt_val    = r_div >> 1;
                end
            end
            ST_START: begin
                if (w_expire) begin
                    if (w_line) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_DATA;
                        w_cnt_load   = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_expire) begin
                    w_cnt_load = 1'b1;
                    if (r_bit_cnt == C_LAST_BIT) begin
                        w_state_next = par_enabled(r_par) ? ST_PARITY : ST_STOP1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_expire) begin
                    w_cnt_load   = 1'b1;
                    w_state_next = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (w_expire) begin
                    if (r_stop2) begin
                        w_cnt_load   = 1'b1;
                        w_state_next = ST_STOP2;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_STOP2: begin
                if (w_expire) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_cfg_div    = (cfg_div < C_MIN) ? C_MIN : cfg_div;
    assign w_enter_idle = (r_state != ST_IDLE) && (w_state_next == ST_IDLE);

    // Active config only moves in a quiet IDLE cycle or on return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div        <= DEFAULT_DIV;
            r_par        <= DEFAULT_PAR;
            r_stop2      <= DEFAULT_STOP2;
            r_pend_vld   <= 1'b0;
            r_pend_div   <= '0;
            r_pend_par   <= 2'b00;
            r_pend_stop2 <= 1'b0;
        end else if ((r_state == ST_IDLE) && cfg_load && !w_fall) begin
            r_div   <= w_cfg_div;
            r_par   <= cfg_par;
            r_stop2 <= cfg_stop2;
        end else if (w_enter_idle) begin
            if (cfg_load) begin
                r_div   <= w_cfg_div;
                r_par   <= cfg_par;
                r_stop2 <= cfg_stop2;
            end else if (r_pend_vld) begin
                r_div   <= r_pend_div;
                r_par   <= r_pend_par;
                r_stop2 <= r_pend_stop2;
            end
            r_pend_vld <= 1'b0;
        end else if (cfg_load) begin
            r_pend_vld   <= 1'b1;
            r_pend_div   <= w_cfg_div;
            r_pend_par   <= cfg_par;
            r_pend_stop2 <= cfg_stop2;
        end
    end

    assign w_par_calc = (^r_shift) ^ w_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_par_acc   <= 1'b0;
            r_frame_acc <= 1'b0;
            r_break_acc <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_expire) begin
            case (r_state)
                ST_START: begin
                    r_bit_cnt   <= '0;
                    r_par_acc   <= 1'b0;
                    r_frame_acc <= 1'b0;
                    r_break_acc <= 1'b0;
                    r_zero      <= 1'b1;
                end
                ST_DATA: begin
                    r_shift   <= {w_line, r_shift[DATA_W-1:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_line) r_zero <= 1'b0;
                end
                ST_PARITY: begin
                    r_par_acc <= (r_par == PAR_ODD) ? ~w_par_calc : w_par_calc;
                    if (w_line) r_zero <= 1'b0;
                end
                ST_STOP1: begin
                    if (!w_line) r_frame_acc <= 1'b1;
                    r_break_acc <= r_zero & ~w_line;
                end
                ST_STOP2: begin
                    if (!w_line) r_frame_acc <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_hs = r_rx_valid & rx_ready;

    // A same-cycle handshake frees the register for the word finishing in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_par   <= 1'b0;
            r_rx_frame <= 1'b0;
            r_rx_break <= 1'b0;
            r_rx_ovr   <= 1'b0;
        end else begin
            if ((r_state == ST_DONE) && (!r_rx_valid || w_hs)) begin
                r_rx_data  <= r_shift;
                r_rx_par   <= r_par_acc;
                r_rx_frame <= r_frame_acc;
                r_rx_break <= r_break_acc;
                r_rx_valid <= 1'b1;
            end else if (w_hs) begin
                r_rx_valid <= 1'b0;
            end
            if (w_hs) begin
                r_rx_ovr <= 1'b0;
            end else if ((r_state == ST_DONE) && r_rx_valid) begin
                r_rx_ovr <= 1'b1;
            end
        end
    end

    assign rx_data      = r_rx_data;
    assign rx_valid     = r_rx_valid;
    assign rx_par_err   = r_rx_par;
    assign rx_frame_err = r_rx_frame;
    assign rx_break     = r_rx_break;
    assign rx_overrun   = r_rx_ovr;
    assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx_cfg                                                             |
// | Directed scoreboard bench for uart_rx_cfg (DATA_W=8, DEFAULT_DIV=16).      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_uart_rx_cfg;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in        = 1'b1;
    logic        cfg_load  = 1'b0;
    logic [15:0] cfg_div   = 16'd16;
    logic [1:0]  cfg_par   = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic        rx_ready  = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_par_err, rx_frame_err, rx_break, rx_overrun, busy;

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .DATA_W        (8),
        .DIV_W         (16),
        .DEFAULT_DIV   (16'd16),
        .DEFAULT_PAR   (2'b00),
        .DEFAULT_STOP2 (1'b0),
        .MIN_DIV       (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in           (in),
        .cfg_load     (cfg_load),
        .cfg_div      (cfg_div),
        .cfg_par      (cfg_par),
        .cfg_stop2    (cfg_stop2),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_par_err   (rx_par_err),
        .rx_frame_err (rx_frame_err),
        .rx_break     (rx_break),
        .rx_overrun   (rx_overrun),
        .busy         (busy)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        logic       brk;
    } exp_t;

    exp_t sb[$];
    exp_t m_got, m_exp;
    int   total = 0;
    int   bad   = 0;
    int   valid_cycles = 0;

    // Every accepted word is popped from the scoreboard and compared.
    always @(negedge clk) begin
        if (rx_valid) valid_cycles++;
        if (!rst && rx_valid && rx_ready) begin
            m_got = {rx_data, rx_par_err, rx_frame_err, rx_break};
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL word_unexpected got=%h expected=none", m_got);
            end
            if (sb.size() != 0) begin
                m_exp = sb.pop_front();
                total++;
                assert (m_got === m_exp) else begin
                    bad++;
                    $error("FAIL word {data,pe,fe,brk} got=%h expected=%h", m_got, m_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe, input logic brk);
        exp_t e;
        e = {d, pe, fe, brk};
        sb.push_back(e);
    endtask

    task automatic cfg_apply(input int div, input logic [1:0] par, input logic s2);
        cfg_div   = 16'(div);
        cfg_par   = par;
        cfg_stop2 = s2;
        cfg_load  = 1'b1;
        tick();
        cfg_load  = 1'b0;
    endtask

    // Drives n bits LSB first, div cycles each; optional cfg_load pulse at bit load_at.
    task automatic send_raw(input logic [15:0] v, input int n, input int div, input int load_at);
        for (int i = 0; i < n; i++) begin
            in = v[i];
            for (int c = 0; c < div; c++) begin
                cfg_load = (i == load_at) && (c == 0);
                tick();
            end
        end
        cfg_load = 1'b0;
        in       = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int div, input bit par_en,
                              input logic pbit, input logic s1, input bit two_stop,
                              input logic s2, input int load_at);
        logic [15:0] v;
        int          n;
        v      = '1;
        v[0]   = 1'b0;
        v[8:1] = d;
        n      = 9;
        if (par_en) begin
            v[n] = pbit;
            n++;
        end
        v[n] = s1;
        n++;
        if (two_stop) begin
            v[n] = s2;
            n++;
        end
        send_raw(v, n, div, load_at);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        int v0;
        repeat (3) tick();
        check("rst_valid", rx_valid, 1'b0);
        check("rst_data", rx_data, 8'h00);
        check("rst_flags", {rx_par_err, rx_frame_err, rx_break, rx_overrun}, 4'b0000);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(4);

        // Default 8N1 at divisor 16, consumer always ready
        v0 = valid_cycles;
        push(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 16, 0, 1'b0, 1'b1, 0, 1'b1, -1);
        idle(20);
        check("t1_valid_pulse", 32'(valid_cycles - v0), 1);
        check("t1_busy_after", busy, 1'b0);
        check("t1_drained", sb.size(), 0);

        // Even parity, two stop bits, divisor 8
        cfg_apply(8, 2'b01, 1'b1);
        push(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 1, 1'b0, 1'b1, 1, 1'b1, -1);
        idle(16);
        push(8'h3C, 1'b1, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 1, 1'b1, 1'b1, 1, 1'b1, -1);
        idle(16);
        push(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'h3C, 8, 1, 1'b0, 1'b1, 1, 1'b0, -1);
        idle(16);
        cfg_apply(8, 2'b10, 1'b1);
        push(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 8, 1, 1'b1, 1'b1, 1, 1'b1, -1);
        idle(16);
        push(8'h07, 1'b1, 1'b0, 1'b0);
        send_frame(8'h07, 8, 1, 1'b1, 1'b1, 1, 1'b1, -1);
        idle(16);
        check("t2_drained", sb.size(), 0);

        // False start, frame error, break
        cfg_apply(16, 2'b00, 1'b0);
        v0 = valid_cycles;
        in = 1'b0;
        idle(3);
        in = 1'b1;
        idle(4);
        check("t3_glitch_busy", busy, 1'b1);
        idle(24);
        check("t3_glitch_idle", busy, 1'b0);
        check("t3_glitch_novalid", 32'(valid_cycles - v0), 0);
        push(8'h81, 1'b0, 1'b1, 1'b0);
        send_frame(8'h81, 16, 0, 1'b0, 1'b0, 0, 1'b1, -1);
        idle(20);
        push(8'h00, 1'b0, 1'b1, 1'b1);
        send_raw(16'h0000, 12, 16, -1);
        idle(20);
        check("t3_drained", sb.size(), 0);

        // Overrun with a stalled consumer
        rx_ready = 1'b0;
        push(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 16, 0, 1'b0, 1'b1, 0, 1'b1, -1);
        idle(4);
        send_frame(8'h22, 16, 0, 1'b0, 1'b1, 0, 1'b1, -1);
        idle(10);
        check("t4_valid_held", rx_valid, 1'b1);
        check("t4_data_first", rx_data, 8'h11);
        check("t4_overrun_set", rx_overrun, 1'b1);
        rx_ready = 1'b1;
        tick();
        check("t4_valid_clear", rx_valid, 1'b0);
        check("t4_overrun_clear", rx_overrun, 1'b0);
        check("t4_drained", sb.size(), 0);

        // Config change mid-frame is deferred; divisor 2 clamps to 4
        cfg_div   = 16'd2;
        cfg_par   = 2'b00;
        cfg_stop2 = 1'b0;
        push(8'hC3, 1'b0, 1'b0, 1'b0);
        send_frame(8'hC3, 16, 0, 1'b0, 1'b1, 0, 1'b1, 3);
        idle(20);
        push(8'h96, 1'b0, 1'b0, 1'b0);
        send_frame(8'h96, 4, 0, 1'b0, 1'b1, 0, 1'b1, -1);
        idle(12);
        check("t5_drained", sb.size(), 0);

        // Reset mid-DATA aborts the frame and restores the default divisor
        send_raw(16'hFFFE, 4, 4, -1);
        rst = 1'b1;
        in  = 1'b1;
        tick();
        check("t6_rst_valid", rx_valid, 1'b0);
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_flags", {rx_par_err, rx_frame_err, rx_break, rx_overrun}, 4'b0000);
        check("t6_rst_busy", busy, 1'b0);
        rst = 1'b0;
        idle(4);
        push(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 16, 0, 1'b0, 1'b1, 0, 1'b1, -1);
        idle(20);

        for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
        check("final_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Runtime-configurable UART receiver, the parametrised successor of the fixed-rate serial front end feeding the colour/config decoder. Data width is set at build time. Baud divisor, parity mode and stop-bit count are set at runtime. Adds a 2-flop input synchroniser, false-start rejection, parity/frame/break detection, and a one-entry valid/ready output register with sticky overrun.

Parameters:
DATA_W, 8, data bits per frame (5..12), LSB first
DIV_W, 16, width of the baud divisor (clock cycles per bit)
DEFAULT_DIV, 10416, divisor after reset (9600 baud at 100 MHz)
DEFAULT_PAR, 2'b00, parity mode after reset: 00 none, 01 even, 10 odd, 11 treated as none
DEFAULT_STOP2, 1'b0, stop bits after reset: 0 means one, 1 means two
MIN_DIV, 4, divisor floor; smaller loaded values are clamped to MIN_DIV

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in  in  1  asynchronous serial line, idle high
cfg_load  in  1  one-cycle strobe: capture cfg_div/cfg_par/cfg_stop2
cfg_div  in  DIV_W  new divisor
cfg_par  in  2  new parity mode
cfg_stop2  in  1  new stop-bit count
rx_data  out  DATA_W  received word
rx_valid  out  1  rx_data holds an unread word
rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
rx_par_err  out  1  parity error for the word in rx_data
rx_frame_err  out  1  a stop bit was sampled low for the word in rx_data
rx_break  out  1  data, parity and first stop bit all sampled 0
rx_overrun  out  1  sticky: a frame completed while rx_valid=1 and was dropped
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0. FSM goes to IDLE. Active config reloads DEFAULT_*. Any pending config is discarded. Synchroniser flops are preset to 1. Reset mid-frame aborts the frame; nothing is delivered.
- `in` passes through 2 flops; every reference to "line" below means the synchronised signal (2-cycle latency).
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, DONE.
- IDLE: on a line falling edge (prev 1, now 0), load the bit counter with div/2 and go to START.
- START: on counter expiry, sample the line. If 1, it is a false start: go back to IDLE with no flags. If 0, load div and go to DATA.
- DATA: sample at each expiry (mid-bit), shifting LSB first. After DATA_W samples, go to PARITY if parity is enabled, otherwise STOP1.
- PARITY: sample the parity bit. Even mode: data ^ bit must be 0. Odd mode: data ^ bit must be 1. A mismatch sets par_err.
- STOP1 / STOP2: sample the stop bit; a 0 sets frame_err. STOP2 is entered only if stop2=1.
- Break: set when all data bits = 0, parity bit (if any) = 0 and STOP1 = 0. A break frame also sets frame_err.
- DONE: lasts one cycle, then IDLE. DONE does not wait for a full stop bit, so the next start edge is detected immediately.
- Delivery, in DONE:
  - If rx_valid=0, or a handshake occurs this same cycle: load rx_data and the error flags, set rx_valid=1 on the next edge. rx_valid rises 1 cycle after the final stop-bit sample.
  - Otherwise drop the frame and set rx_overrun.
- Handshake: rx_valid && rx_ready clears rx_valid and rx_overrun. A handshake in the same cycle as DONE loads the new word and keeps rx_valid=1; rx_overrun still clears.
- Config:
  - cfg_load in IDLE with no falling edge that cycle: applies on the next edge.
  - Otherwise the config is latched as pending and applied on entry to IDLE. A later cfg_load overwrites pending.
  - cfg_div < MIN_DIV is clamped. The active config never changes mid-frame.
- Counter: DIV_W bits, down-counting; expiry is count==1. div/2 uses a floor shift. Arithmetic is unsigned, with no wrap (the counter is reloaded at expiry).
- busy = (state != IDLE).

Decomposition:
- Shared package uart_pkg: parity encodings (PAR_NONE/EVEN/ODD), the FSM state enum, and the MIN_DIV constant.
- One sub-module: uart_baud_cnt, a loadable down-counter with an expiry pulse.
- The synchroniser, shift register and FSM stay in the top module.

Test Plan:
1. DEFAULT_DIV=16, 8N1, send 0xA5 with rx_ready=1 → rx_valid pulses 1 cycle, rx_data=0xA5, no flags, busy=0 afterwards.
2. cfg_load div=8, par=01, stop2=1; send 0x3C with correct parity 0 and two stop bits → 0x3C, no errors. Resend with parity bit 1 → rx_par_err=1.
3. Low glitch of 3 cycles at div=16 → no START acceptance, busy returns 0, rx_valid stays 0. Then a frame with the stop bit forced 0 → rx_frame_err=1. Then an all-zero line for 12 bits → rx_break=1.
4. rx_ready=0; send 0x11 then 0x22 → rx_data=0x11, rx_overrun=1. Raise rx_ready → rx_valid=0, rx_overrun=0.
5. cfg_load div=2 mid-frame at div=16 → current frame decodes at 16. Next frame decodes at div=4 (clamped).
6. Assert rst for 1 cycle mid-DATA → all outputs 0, div back to DEFAULT_DIV. The following clean 0x5A frame is received correctly.
